game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
- Top-level match sequencer for the Pong engine: a state machine that runs startup, serve, play, pause and game over, and keeps both players' scores.
- Drives the velocity mapper's sq_missed, game_over and game_startup controls.
- Gates ball motion through ball_enable and tells the serve logic which direction to launch.
- Sits between the ball/collision logic, which reports out-of-bounds events, and the velocity mapper and score renderer.

Parameters:
- WIN_SCORE, 7, points needed to win; range 1..2^SCORE_WIDTH-1.
- SERVE_FRAMES, 60, frame_tick pulses the ball is held before each serve.
- OVER_FRAMES, 180, minimum frame_tick pulses the game-over screen is held before start_btn is accepted.
- SCORE_WIDTH, 4, width of each score register.
- CNT_WIDTH, $clog2(max(SERVE_FRAMES,OVER_FRAMES)+1), width of the frame counter.

Ports:
- clk_0, input, 1, 25.175MHz pixel clock.
- rst, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- start_btn, input, 1, start/pause button level, already synchronised to clk_0, active-high.
- sq_out_left, input, 1, one-cycle pulse: square passed the left boundary.
- sq_out_right, input, 1, one-cycle pulse: square passed the right boundary.
- game_startup, output, 1, high in STARTUP.
- game_over, output, 1, high in OVER.
- sq_missed, output, 1, one-cycle pulse per scored or void rally.
- ball_enable, output, 1, high only in PLAY.
- serve_dir, output, 1, 0 = serve toward the right player, 1 = serve toward the left player.
- score_l, output, SCORE_WIDTH, left player score.
- score_r, output, SCORE_WIDTH, right player score.
- winner, output, 1, 0 = left, 1 = right; meaningful only while game_over = 1.

Behaviour:
- All outputs are registered. State, counter and button-history flops reset asynchronously on rst = 0.
- Reset values:
  - state = STARTUP, so game_startup = 1.
  - game_over = 0, sq_missed = 0, ball_enable = 0, serve_dir = 0.
  - score_l = 0, score_r = 0, winner = 0, frame counter = 0.
  - start_prev = 1, so a button held through reset does not generate an edge.
- start_edge = start_btn & ~start_prev; start_prev is updated every cycle.
- Frame counter: cleared on every state transition; increments on each frame_tick while in SERVE or OVER; saturates at its maximum.
- STARTUP:
  - start_edge -> SERVE; clear both scores; serve_dir = 0.
  - All out-of-bounds inputs are ignored.
- SERVE:
  - ball_enable = 0.
  - When a frame_tick arrives with counter == SERVE_FRAMES-1 -> PLAY on the next edge.
  - start_edge is ignored.
  - Total hold is SERVE_FRAMES ticks, counted from the first tick after entry.
- PLAY, on a given cycle, in priority order:
  - a) sq_out_left and sq_out_right both high: void rally. sq_missed pulses the next cycle, scores and serve_dir are unchanged, -> SERVE.
  - b) sq_out_left only: score_r += 1, serve_dir = 1, sq_missed pulses, -> SERVE. If the new score_r == WIN_SCORE, go -> OVER instead, with winner = 1.
  - c) sq_out_right only: score_l += 1, serve_dir = 0, sq_missed pulses, -> SERVE. If the new score_l == WIN_SCORE, go -> OVER instead, with winner = 0.
  - d) start_edge alone -> PAUSE.
  - An out-of-bounds event takes priority over a same-cycle start_edge.
- Latency: an out pulse on cycle N produces sq_missed, the updated score and the new state all visible at cycle N+1. sq_missed is exactly 1 cycle wide.
- PAUSE:
  - ball_enable = 0.
  - Out-of-bounds pulses are ignored.
  - start_edge -> PLAY; no serve delay, and scores are kept.
- OVER:
  - game_over = 1, ball_enable = 0; scores and winner are frozen.
  - start_edge is ignored until the counter reaches OVER_FRAMES.
  - After that, start_edge -> STARTUP; scores are cleared on the next STARTUP->SERVE transition, so the final score stays visible on the startup screen.
- Exactly one of game_startup, game_over, ball_enable can be high, or none (in SERVE and PAUSE).
- Score arithmetic never exceeds WIN_SCORE. No wrap is possible by construction; out-of-bounds pulses are ignored outside PLAY.
- frame_tick coincident with a state transition is not counted.
- Reset asserted mid-rally, or in any state, returns immediately to the reset values listed above. No pulse is emitted on reset release.

Test Plan:
- Reset with start_btn held high, then release and press again -> no transition until the second rising edge. After it: state SERVE, score_l = score_r = 0, game_startup = 0.
- SERVE_FRAMES = 3, ticks every 10 cycles -> ball_enable rises exactly 1 cycle after the 3rd tick; earlier start_btn presses have no effect.
- In PLAY, pulse sq_out_left at cycle N -> at N+1: sq_missed = 1 for one cycle, score_r = 1, serve_dir = 1, ball_enable = 0. Then pulse sq_out_right -> score_l = 1, serve_dir = 0.
- In PLAY, sq_out_left and sq_out_right in the same cycle -> sq_missed pulses once, scores unchanged. A start_edge in the same cycle as sq_out_right -> state SERVE, not PAUSE.
- WIN_SCORE = 2: right player scores twice -> game_over = 1, winner = 1, score_r = 2. Presses before OVER_FRAMES ticks are ignored; a press after them gives game_startup = 1 with score_r still 2, and the next press clears the scores.
- In PLAY, press start -> PAUSE with ball_enable = 0 and an out pulse ignored (no sq_missed); press again -> PLAY immediately. Assert rst mid-PLAY -> all outputs take their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Pong match sequencer: startup, serve hold, play, pause and game-over handling
// with per-player score keeping. All outputs are registered.
module game_flow_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int SCORE_WIDTH  = 4,
    parameter int CNT_WIDTH    = $clog2(((SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES) + 1)
) (
    input  logic                   clk_0,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   start_btn,
    input  logic                   sq_out_left,
    input  logic                   sq_out_right,
    output logic                   game_startup,
    output logic                   game_over,
    output logic                   sq_missed,
    output logic                   ball_enable,
    output logic                   serve_dir,
    output logic [SCORE_WIDTH-1:0] score_l,
    output logic [SCORE_WIDTH-1:0] score_r,
    output logic                   winner
);

    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_SERVE   = 3'd1;
    localparam logic [2:0] ST_PLAY    = 3'd2;
    localparam logic [2:0] ST_PAUSE   = 3'd3;
    localparam logic [2:0] ST_OVER    = 3'd4;

    localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]   SERVE_LAST = CNT_WIDTH'(SERVE_FRAMES - 1);
    localparam logic [CNT_WIDTH-1:0]   OVER_HOLD  = CNT_WIDTH'(OVER_FRAMES);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);

    logic [2:0]             state_r, state_nxt_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic                   start_prev_r;
    logic                   start_edge_s;
    logic [SCORE_WIDTH-1:0] score_l_r, score_l_nxt_s;
    logic [SCORE_WIDTH-1:0] score_r_r, score_r_nxt_s;
    logic [SCORE_WIDTH-1:0] score_inc_s;
    logic                   serve_dir_r, serve_dir_nxt_s;
    logic                   winner_r, winner_nxt_s;
    logic                   sq_missed_nxt_s;
    logic                   game_startup_r, game_over_r, sq_missed_r, ball_enable_r;

    assign start_edge_s = start_btn & ~start_prev_r;

    // Next-state, score and serve-direction decisions
    always_comb begin
        state_nxt_s     = state_r;
        score_l_nxt_s   = score_l_r;
        score_r_nxt_s   = score_r_r;
        serve_dir_nxt_s = serve_dir_r;
        winner_nxt_s    = winner_r;
        sq_missed_nxt_s = 1'b0;
        score_inc_s     = {SCORE_WIDTH{1'b0}};
        case (state_r)
            ST_STARTUP: begin
                if (start_edge_s) begin
                    state_nxt_s     = ST_SERVE;
                    score_l_nxt_s   = {SCORE_WIDTH{1'b0}};
                    score_r_nxt_s   = {SCORE_WIDTH{1'b0}};
                    serve_dir_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_STARTUP;
                end
            end
            ST_SERVE: begin
                if (frame_tick && (cnt_r == SERVE_LAST)) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                // Out-of-bounds events outrank a same-cycle start press
                if (sq_out_left && sq_out_right) begin
                    sq_missed_nxt_s = 1'b1;
                    state_nxt_s     = ST_SERVE;
                end else if (sq_out_left) begin
                    score_inc_s     = score_r_r + SCORE_ONE;
                    score_r_nxt_s   = score_inc_s;
                    serve_dir_nxt_s = 1'b1;
                    sq_missed_nxt_s = 1'b1;
                    if (score_inc_s == WIN_VAL) begin
                        state_nxt_s  = ST_OVER;
                        winner_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SERVE;
                    end
                end else if (sq_out_right) begin
                    score_inc_s     = score_l_r + SCORE_ONE;
                    score_l_nxt_s   = score_inc_s;
                    serve_dir_nxt_s = 1'b0;
                    sq_missed_nxt_s = 1'b1;
                    if (score_inc_s == WIN_VAL) begin
                        state_nxt_s  = ST_OVER;
                        winner_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_SERVE;
                    end
                end else if (start_edge_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (start_edge_s) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (start_edge_s && (cnt_r >= OVER_HOLD)) begin
                    state_nxt_s = ST_STARTUP;
                end else begin
                    state_nxt_s = ST_OVER;
                end
            end
            default: begin
                state_nxt_s = ST_STARTUP;
            end
        endcase
    end

    // Frame counter: restarts on any transition, saturates otherwise
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = {CNT_WIDTH{1'b0}};
        end else if (frame_tick && ((state_r == ST_SERVE) || (state_r == ST_OVER)) && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State, counter, scores and registered outputs
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_STARTUP;
            cnt_r          <= {CNT_WIDTH{1'b0}};
            start_prev_r   <= 1'b1;
            score_l_r      <= {SCORE_WIDTH{1'b0}};
            score_r_r      <= {SCORE_WIDTH{1'b0}};
            serve_dir_r    <= 1'b0;
            winner_r       <= 1'b0;
            game_startup_r <= 1'b1;
            game_over_r    <= 1'b0;
            sq_missed_r    <= 1'b0;
            ball_enable_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            start_prev_r   <= start_btn;
            score_l_r      <= score_l_nxt_s;
            score_r_r      <= score_r_nxt_s;
            serve_dir_r    <= serve_dir_nxt_s;
            winner_r       <= winner_nxt_s;
            game_startup_r <= (state_nxt_s == ST_STARTUP);
            game_over_r    <= (state_nxt_s == ST_OVER);
            sq_missed_r    <= sq_missed_nxt_s;
            ball_enable_r  <= (state_nxt_s == ST_PLAY);
        end
    end

    assign game_startup = game_startup_r;
    assign game_over    = game_over_r;
    assign sq_missed    = sq_missed_r;
    assign ball_enable  = ball_enable_r;
    assign serve_dir    = serve_dir_r;
    assign score_l      = score_l_r;
    assign score_r      = score_r_r;
    assign winner       = winner_r;

endmodule
